// File: rtl/mcycle_if.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_if
// Purpose  : Operation request / result bundle between the condition unit and
//            the multi-cycle multiply/divide engine.
// Revision : 1.0
// ============================================================================
interface mcycle_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy
    );
endinterface
`default_nettype wire

// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_unit
// Purpose  : Iterative shift-add multiplier / restoring divider, one bit per
//            cycle, with sign fix-up applied on the final iteration.
// Revision : 1.0
// ============================================================================
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic CLK,
    input  wire logic Reset,
    mcycle_if.slave   bus
);
    localparam int               c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [c_CW-1:0]  r_count;
    logic             r_is_div;
    logic             r_sign1;
    logic             r_sign2;
    logic             r_divz;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result1;
    logic [WIDTH-1:0] r_result2;
    logic             w_busy;
    logic             w_start;
    logic             w_last;

    assign w_start = (r_state == S_IDLE) && bus.Start;
    assign w_last  = (r_state == S_COMPUTE) && (r_count == c_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.Start) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last)    w_state_next = S_DONE;
            S_DONE:                   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:    w_busy = bus.Start;
            S_COMPUTE: w_busy = 1'b1;
            default:   w_busy = 1'b0;
        endcase
    end

    // ---------------- operand conditioning ----------------
    logic             w_signed_op;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    assign w_signed_op = ~bus.MCycleOp[0];
    assign w_neg1      = w_signed_op & bus.Operand1[WIDTH-1];
    assign w_neg2      = w_signed_op & bus.Operand2[WIDTH-1];
    // Magnitude of the most-negative value is exactly representable unsigned.
    assign w_mag1      = w_neg1 ? -bus.Operand1 : bus.Operand1;
    assign w_mag2      = w_neg2 ? -bus.Operand2 : bus.Operand2;

    // ---------------- one iteration ----------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mag_a : {WIDTH{1'b0}})};
    assign w_div_shift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_div_ge    = {r_hi, r_lo[WIDTH-1]} >= {1'b0, r_mag_b};
    assign w_div_sub   = w_div_shift - r_mag_b;

    always_comb begin
        w_next_hi = w_mul_sum[WIDTH:1];
        w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_next_hi = w_div_ge ? w_div_sub : w_div_shift;
            w_next_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod     = {w_next_hi, w_next_lo};
    assign w_prod_fix = (r_sign1 ^ r_sign2) ? -w_prod : w_prod;
    // Zero divisor leaves the dividend in the remainder; only the quotient is forced.
    assign w_quot     = r_divz ? {WIDTH{1'b1}}
                               : ((r_sign1 ^ r_sign2) ? -w_next_lo : w_next_lo);
    assign w_rem      = r_sign1 ? -w_next_hi : w_next_hi;

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_divz    <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result1 <= '0;
            r_result2 <= '0;
        end else if (w_start) begin
            r_count  <= '0;
            r_is_div <= bus.MCycleOp[1];
            r_sign1  <= w_neg1;
            r_sign2  <= w_neg2;
            r_divz   <= (bus.Operand2 == '0);
            r_mag_a  <= w_mag1;
            r_mag_b  <= w_mag2;
            r_hi     <= '0;
            r_lo     <= bus.MCycleOp[1] ? w_mag1 : w_mag2;
        end else if (r_state == S_COMPUTE) begin
            r_hi <= w_next_hi;
            r_lo <= w_next_lo;
            if (w_last) begin
                r_count <= '0;
                if (r_is_div) begin
                    r_result1 <= w_quot;
                    r_result2 <= w_rem;
                end else begin
                    r_result1 <= w_prod_fix[WIDTH-1:0];
                    r_result2 <= w_prod_fix[2*WIDTH-1:WIDTH];
                end
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.Busy    = w_busy;
    assign bus.Result1 = r_result1;
    assign bus.Result2 = r_result2;
endmodule
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcycle_unit
// Purpose  : Directed and random operations on mcycle_unit, checked against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_mcycle_unit;
    logic CLK;
    logic Reset;
    int   total;
    int   bad;
    logic [31:0] prev_r1;
    logic [31:0] prev_r2;

    mcycle_if #(.WIDTH(32)) mif ();

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (mif.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output logic [31:0] r2);
        logic [63:0] up;
        longint      sa;
        longint      sb;
        longint      sp;
        longint      q;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin sp = sa * sb; r1 = sp[31:0]; r2 = sp[63:32]; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; r1 = up[31:0]; r2 = up[63:32]; end
            2'b10: begin
                if (b == 32'h0) begin r1 = 32'hFFFF_FFFF; r2 = a; end
                else begin q = sa / sb; r = sa % sb; r1 = q[31:0]; r2 = r[31:0]; end
            end
            default: begin
                if (b == 32'h0) begin r1 = 32'hFFFF_FFFF; r2 = a; end
                else begin r1 = a / b; r2 = a % b; end
            end
        endcase
    endtask

    // Entered in IDLE just after a rising edge; leaves in IDLE just after a rising edge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] e1;
        logic [31:0] e2;
        int          busy_cnt;
        int          cycles;
        model(op, a, b, e1, e2);
        mif.Start    = 1'b1;
        mif.MCycleOp = op;
        mif.Operand1 = a;
        mif.Operand2 = b;
        #1;
        busy_cnt = 0;
        cycles   = 0;
        while (mif.Busy === 1'b1 && cycles < 100) begin
            busy_cnt++;
            @(posedge CLK);
            #1;
            if (!hold) begin
                mif.Start    = 1'b0;
                mif.Operand1 = $urandom;
                mif.Operand2 = $urandom;
                mif.MCycleOp = 2'($urandom_range(0, 3));
            end
            cycles++;
            if (cycles == 5) check({tag, ".hold"}, {mif.Result2, mif.Result1}, {prev_r2, prev_r1});
        end
        check({tag, ".busy"}, 64'(busy_cnt), 64'd33);
        check({tag, ".r1"}, {32'h0, mif.Result1}, {32'h0, e1});
        check({tag, ".r2"}, {32'h0, mif.Result2}, {32'h0, e2});
        prev_r1 = e1;
        prev_r2 = e2;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        total        = 0;
        bad          = 0;
        prev_r1      = '0;
        prev_r2      = '0;
        CLK          = 1'b0;
        Reset        = 1'b1;
        mif.Start    = 1'b0;
        mif.MCycleOp = 2'b00;
        mif.Operand1 = '0;
        mif.Operand2 = '0;
        #3;
        check("reset.busy", {63'h0, mif.Busy}, 64'h0);
        check("reset.res", {mif.Result2, mif.Result1}, 64'h0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        run_op("umul_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("smul_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("smul_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("udiv_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("sdiv_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0);
        run_op("sdiv_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op("udiv_5_0", 2'b11, 32'd5, 32'd0, 1'b0);
        run_op("sdiv_5_0", 2'b10, 32'd5, 32'd0, 1'b0);
        run_op("sdiv_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("sdiv_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Start held through DONE must not restart; the following IDLE cycle does.
        run_op("hold_start", 2'b01, 32'd11, 32'd13, 1'b1);
        run_op("umul_6_7", 2'b01, 32'd6, 32'd7, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of an operation.
        mif.Start    = 1'b1;
        mif.MCycleOp = 2'b01;
        mif.Operand1 = 32'h1234_5678;
        mif.Operand2 = 32'h0ABC_DEF1;
        @(posedge CLK);
        #1;
        mif.Start = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("midreset.busy", {63'h0, mif.Busy}, 64'h0);
        check("midreset.res", {mif.Result2, mif.Result1}, 64'h0);
        prev_r1 = '0;
        prev_r2 = '0;
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        run_op("udiv_9_2", 2'b11, 32'd9, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
